// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable seconds countdown timer with pause/resume
//
// Counts seconds_left down to zero at one step per CLK_FREQ clocks.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   load          copy load_value into seconds_left and return to IDLE
//   load_value    countdown start value
//   start         begin (from IDLE) or resume (from PAUSE) the countdown
//   pause         freeze the countdown while running
//   seconds_left  remaining seconds (registered)
//   running       high while in RUN (registered)
//   tick          one-cycle pulse on each decrement
//   done          one-cycle pulse on the decrement that reaches zero
module countdown_timer #(
    parameter int CLK_FREQ  = 100000000,
    parameter int SEC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SEC_WIDTH-1:0] load_value,
    input  logic                 start,
    input  logic                 pause,
    output logic [SEC_WIDTH-1:0] seconds_left,
    output logic                 running,
    output logic                 tick,
    output logic                 done
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;

    always_ff @(posedge clk) begin
        // Pulses default low; only a decrement edge raises them.
        tick <= 1'b0;
        done <= 1'b0;
        if (rst) begin
            state        <= IDLE;
            prescaler    <= '0;
            seconds_left <= '0;
            running      <= 1'b0;
        end else if (load) begin
            // A load during RUN aborts silently: no done pulse.
            state        <= IDLE;
            seconds_left <= load_value;
            prescaler    <= '0;
            running      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // pause outranks start; a zero count cannot be started.
                    if (start && !pause && seconds_left != '0) begin
                        state     <= RUN;
                        prescaler <= '0;
                        running   <= 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        // Hold everything, even on the terminal prescaler
                        // value; that tick fires on the first edge after resume.
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (seconds_left == '0) begin
                        // Unreachable through the ports; keeps the count from wrapping.
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (prescaler == PRE_LAST) begin
                        prescaler    <= '0;
                        seconds_left <= seconds_left - SEC_WIDTH'(1);
                        tick         <= 1'b1;
                        if (seconds_left == SEC_WIDTH'(1)) begin
                            done    <= 1'b1;
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                PAUSE: begin
                    // Resume keeps the held prescaler phase.
                    if (start && !pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed scoreboard bench for countdown_timer
module tb_countdown_timer;

    localparam int CF = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [SW-1:0] load_value = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [SW-1:0] seconds_left;
    logic          running;
    logic          tick;
    logic          done;

    countdown_timer #(.CLK_FREQ(CF), .SEC_WIDTH(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .load_value   (load_value),
        .start        (start),
        .pause        (pause),
        .seconds_left (seconds_left),
        .running      (running),
        .tick         (tick),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [SW-1:0] sec;
        logic          run;
        logic          tk;
        logic          dn;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ticks_seen = 0;
    int   dones_seen = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs,
    // then pop and compare #1 after the edge.
    task automatic step(input logic r, input logic l, input logic [SW-1:0] lv,
                        input logic s, input logic p, input string tag,
                        input int es, input logic er, input logic et, input logic ed);
        exp_t e;
        @(negedge clk);
        rst = r; load = l; load_value = lv; start = s; pause = p;
        sb.push_back('{tag: tag, sec: SW'(es), run: er, tk: et, dn: ed});
        @(posedge clk);
        #1;
        if (tick === 1'b1) ticks_seen++;
        if (done === 1'b1) dones_seen++;
        e = sb.pop_front();
        check({e.tag, ".sec"},  int'(seconds_left), int'(e.sec));
        check({e.tag, ".run"},  int'(running),      int'(e.run));
        check({e.tag, ".tick"}, int'(tick),         int'(e.tk));
        check({e.tag, ".done"}, int'(done),         int'(e.dn));
    endtask

    initial begin
        int t0;
        int d0;

        // 1. reset overrides load/start
        step(1, 1, 4'd7, 1, 0, "rst0", 0, 0, 0, 0);
        step(1, 1, 4'd7, 1, 0, "rst1", 0, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0, "rst_rel", 0, 0, 0, 0);

        // 2. nominal countdown from 3
        step(0, 1, 4'd3, 0, 0, "nom_load", 3, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "nom_e0", 3, 1, 0, 0);
        for (int e = 1; e <= 12; e++)
            step(0, 0, 4'd0, 0, 0, $sformatf("nom_e%0d", e),
                 3 - e / CF, e < 12, (e % CF) == 0, e == 12);
        step(0, 0, 4'd0, 0, 0, "nom_after", 0, 0, 0, 0);

        // 3. pause at prescaler=1, resume later
        step(0, 1, 4'd2, 0, 0, "pr_load", 2, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "pr_e0", 2, 1, 0, 0);
        for (int e = 1; e <= 5; e++)
            step(0, 0, 4'd0, 0, 0, $sformatf("pr_e%0d", e), 2 - e / CF, 1, e == 4, 0);
        for (int e = 6; e <= 15; e++)
            step(0, 0, 4'd0, 0, 1, $sformatf("pr_e%0d", e), 1, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "pr_e16", 1, 1, 0, 0);
        step(0, 0, 4'd0, 0, 0, "pr_e17", 1, 1, 0, 0);
        step(0, 0, 4'd0, 0, 0, "pr_e18", 1, 1, 0, 0);
        step(0, 0, 4'd0, 0, 0, "pr_e19", 0, 0, 1, 1);

        // 4. pause coinciding with the terminal prescaler value
        step(0, 1, 4'd2, 0, 0, "pt_load", 2, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "pt_e0", 2, 1, 0, 0);
        for (int e = 1; e <= 3; e++)
            step(0, 0, 4'd0, 0, 0, $sformatf("pt_e%0d", e), 2, 1, 0, 0);
        step(0, 0, 4'd0, 0, 1, "pt_e4", 2, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0, "pt_e5", 2, 0, 0, 0);
        step(0, 0, 4'd0, 1, 1, "pt_both", 2, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "pt_resume", 2, 1, 0, 0);
        step(0, 0, 4'd0, 0, 0, "pt_deferred", 1, 1, 1, 0);
        for (int e = 1; e <= 3; e++)
            step(0, 0, 4'd0, 0, 0, $sformatf("pt_r%0d", e), 1, 1, 0, 0);
        step(0, 0, 4'd0, 0, 0, "pt_end", 0, 0, 1, 1);

        // 5. abort by load, then start with zero count
        step(0, 1, 4'd5, 0, 0, "ab_load", 5, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "ab_e0", 5, 1, 0, 0);
        for (int e = 1; e <= 5; e++)
            step(0, 0, 4'd0, 0, 0, $sformatf("ab_e%0d", e), 5 - e / CF, 1, e == 4, 0);
        step(0, 1, 4'd9, 1, 0, "ab_e6", 9, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0, "ab_e7", 9, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0, "ab_e8", 9, 0, 0, 0);
        step(0, 1, 4'd0, 0, 0, "z_load", 0, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, "z_start", 0, 0, 0, 0);
        step(0, 0, 4'd0, 0, 1, "z_pause", 0, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0, "z_idle", 0, 0, 0, 0);

        // 6. full range from 15 with stray start pulses
        step(0, 1, 4'd15, 0, 0, "fr_load", 15, 0, 0, 0);
        t0 = ticks_seen;
        d0 = dones_seen;
        step(0, 0, 4'd0, 1, 0, "fr_e0", 15, 1, 0, 0);
        for (int e = 1; e <= 60; e++)
            step(0, 0, 4'd0, (e == 10 || e == 25 || e == 37), 0, $sformatf("fr_e%0d", e),
                 15 - e / CF, e < 60, (e % CF) == 0, e == 60);
        step(0, 0, 4'd0, 0, 0, "fr_after", 0, 0, 0, 0);
        check("fr_tick_count", ticks_seen - t0, 15);
        check("fr_done_count", dones_seen - d0, 1);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable seconds countdown timer. It counts down from a preset value to zero at a rate of 1 per second, derived from the 100 MHz board clock. It is the down-counting counterpart of the free-running seconds up-counter and feeds the same display and LED logic. It supports load, start, pause and resume. It asserts a one-cycle done pulse on reaching zero.

Parameters:
CLK_FREQ, 100000000, clock cycles per second; must be >= 2; set to 4 in simulation benches.
SEC_WIDTH, 4, width of seconds count (0..15).

Ports:
clk  input  1  system clock (100 MHz on board)
rst  input  1  synchronous, active-high reset
load  input  1  load load_value into seconds_left (level sampled each posedge)
load_value  input  SEC_WIDTH  countdown start value
start  input  1  begin or resume countdown
pause  input  1  freeze countdown
seconds_left  output  SEC_WIDTH  remaining seconds (registered)
running  output  1  high while in RUN state
tick  output  1  one-cycle pulse on each decrement
done  output  1  one-cycle pulse on the decrement that reaches 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). All state updates on posedge clk.
- Internal prescaler: width $clog2(CLK_FREQ), range 0..CLK_FREQ-1. Exactly CLK_FREQ cycles per second, no off-by-one.
- Reset: state=IDLE, prescaler=0, seconds_left=0, running=0, tick=0, done=0. Reset overrides all other inputs.
- States: IDLE, RUN, PAUSE. running = (state==RUN), registered.
- Input priority per cycle: rst > load > pause > start.
- load (any state):
  - state -> IDLE, seconds_left <= load_value, prescaler <= 0, tick=done=0.
  - A load during RUN aborts the countdown with no done pulse.
- IDLE:
  - start with seconds_left != 0: -> RUN, prescaler <= 0.
  - start with seconds_left == 0: ignored, stays IDLE, no done.
  - pause in IDLE: ignored.
- RUN, no pause:
  - If prescaler < CLK_FREQ-1: prescaler++.
  - At prescaler == CLK_FREQ-1: prescaler <= 0, seconds_left <= seconds_left-1, tick=1.
  - If seconds_left was 1: also done=1, state -> IDLE, running drops the same edge.
- RUN with pause: -> PAUSE. prescaler and seconds_left are held. No tick, even if prescaler == CLK_FREQ-1 that cycle; the deferred tick fires on the first RUN edge after resume.
- PAUSE:
  - start (without pause) -> RUN, prescaler continues from its held value.
  - pause+start together: stays PAUSE.
- start while in RUN: no effect (does not restart prescaler).
- Timing: with the start-sampling edge as edge 0, the first decrement/tick appears after edge CLK_FREQ. Subsequent ticks follow every CLK_FREQ edges. Countdown from N (no pause) lasts N*CLK_FREQ cycles.
- tick/done are single-cycle, never asserted outside a decrement edge. seconds_left never wraps below 0.

Test Plan:
(All with CLK_FREQ=4.)
1. Reset: hold rst 2 cycles with load=1, start=1 -> seconds_left=0, running=0, tick=0, done=0; state IDLE after release.
2. Nominal countdown: load 3, then start at edge 0 -> seconds_left 3→2 at edge 4, 2→1 at edge 8, 1→0 at edge 12. tick at edges 4/8/12, done only at edge 12, running low from edge 12.
3. Pause/resume: load 2, start; pause at edge 6 (prescaler=1) for 10 cycles -> seconds_left stays 1, no tick. start at edge 16 -> decrement to 0 with done at edge 19.
4. Pause at terminal count: load 2, start; pause coincident with edge 4 -> no tick, seconds_left stays 2. Resume -> tick and seconds_left=1 on the first RUN edge.
5. Abort and zero: load 5, start; load 9 at edge 6 -> seconds_left=9, IDLE, no done. start with seconds_left=0 -> stays IDLE, running=0, no done.
6. Full range: load 15, start -> exactly 15 ticks over 60 cycles, single done at edge 60. Extra start pulses mid-run do not shift tick timing.
